// File: rtl/rle_encoder_if.sv
// rle_encoder_if -- pixel input stream and encoded word output stream of the
// run-length encoder.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. A source holds valid and its payload unchanged until that
// edge; ready may change freely and never depends on valid.
//
//   pix_valid/pix_colour/pix_last  source -> encoder  pixel stream
//   pix_ready                      encoder -> source
//   out_valid/out_data             encoder -> sink    {run_len[9:0], colour[5:0]}
//   out_ready                      sink -> encoder
//
// Modports: master = pixel source / word sink, slave = the encoder.
interface rle_encoder_if;
  logic        pix_valid;
  logic [5:0]  pix_colour;
  logic        pix_last;
  logic        pix_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    output pix_valid, pix_colour, pix_last, out_ready,
    input  pix_ready, out_valid, out_data
  );

  modport slave (
    input  pix_valid, pix_colour, pix_last, out_ready,
    output pix_ready, out_valid, out_data
  );
endinterface

// File: rtl/rle_encoder.sv
// rle_encoder -- row-based run-length encoder for 6-bit RRGGBB pixels.
//
// Consecutive equal-colour pixels of a row are merged into one 16-bit word
// {run_len[9:0], colour[5:0]}. A run is closed on a colour change, on
// reaching MAX_RUN pixels, or at the end of a row (pix_last). Runs never
// cross rows.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        rle_encoder_if.slave (pixel input, word output)
//   word_count number of words handed off since reset, wraps at 16'hFFFF
//   state_dbg  current FSM state (0 EMPTY, 1 RUN, 2 FLUSH, 3 MARK)
//
// Optional build macro RLE_ENC_EOL_MARKER_EN: after the last run of each
// row a length-0 word 16'h0000 is emitted as an end-of-row marker.
module rle_encoder #(
  parameter int MAX_RUN = 1023
) (
  input  logic        clk,
  input  logic        rst,
  rle_encoder_if.slave bus,
  output logic [15:0] word_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
`ifdef RLE_ENC_EOL_MARKER_EN
    S_FLUSH = 2'd2,
    S_MARK  = 2'd3
`else
    S_FLUSH = 2'd2
`endif
  } state_e;

  // State entered once the final run of a row has been written.
`ifdef RLE_ENC_EOL_MARKER_EN
  localparam state_e EOL_STATE = S_MARK;
`else
  localparam state_e EOL_STATE = S_EMPTY;
`endif

  localparam logic [9:0] MAX_LEN = 10'(MAX_RUN);

  state_e      state_q, state_d;
  logic [9:0]  run_len_q, run_len_d;
  logic [5:0]  run_colour_q, run_colour_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] word_count_q, word_count_d;

  logic        out_free;
  logic        accept;
  logic        extend;
  logic        wr;
  logic [15:0] wr_data;

  // Output register may take a new word if empty or being drained this cycle.
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.pix_valid && bus.pix_ready;
  // Pixel continues the held run (same colour and room left).
  assign extend   = (bus.pix_colour == run_colour_q) && (run_len_q < MAX_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      run_len_q    <= '0;
      run_colour_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      run_colour_q <= run_colour_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  // Next-state logic, including which word (if any) is written this cycle
  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    run_colour_d = run_colour_q;
    wr           = 1'b0;
    wr_data      = out_data_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          if (bus.pix_last) begin
            wr        = 1'b1;
            wr_data   = {10'd1, bus.pix_colour};
            run_len_d = '0;
            state_d   = EOL_STATE;
          end else begin
            run_len_d    = 10'd1;
            run_colour_d = bus.pix_colour;
            state_d      = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (extend && bus.pix_last) begin
            wr        = 1'b1;
            wr_data   = {run_len_q + 10'd1, run_colour_q};
            run_len_d = '0;
            state_d   = EOL_STATE;
          end else if (extend) begin
            run_len_d = run_len_q + 10'd1;
          end else begin
            // Split: old run goes out now, the new pixel starts a fresh run.
            // If it also ends the row it must wait a cycle in FLUSH.
            wr           = 1'b1;
            wr_data      = {run_len_q, run_colour_q};
            run_len_d    = 10'd1;
            run_colour_d = bus.pix_colour;
            state_d      = bus.pix_last ? S_FLUSH : S_RUN;
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          wr        = 1'b1;
          wr_data   = {run_len_q, run_colour_q};
          run_len_d = '0;
          state_d   = EOL_STATE;
        end
      end
`ifdef RLE_ENC_EOL_MARKER_EN
      S_MARK: begin
        if (out_free) begin
          wr      = 1'b1;
          wr_data = 16'h0000;
          state_d = S_EMPTY;
        end
      end
`endif
      default: state_d = S_EMPTY;
    endcase
  end

  // Output register and counter update
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 16'd1;
    end
    if (wr) begin
      out_valid_d = 1'b1;
      out_data_d  = wr_data;
    end
  end

  // Outputs
  always_comb begin
    bus.pix_ready = ((state_q == S_EMPTY) || (state_q == S_RUN)) && out_free;
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    word_count    = word_count_q;
    state_dbg     = state_q;
  end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 Parameter MAX_RUN, default 1023, is the maximum pixels per run word (legal range 1..1023).
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port pix_valid, input, 1: pix_colour/pix_last are valid this cycle.
REQ-005 Port pix_colour, input, 6: pixel colour, RRGGBB.
REQ-006 Port pix_last, input, 1: the accompanying pixel is the last of its row.
REQ-007 Port pix_ready, output, 1: the encoder accepts a pixel this cycle when pix_valid && pix_ready.
REQ-008 Port out_valid, output, 1: out_data holds a word.
REQ-009 Port out_data, output, 16: the encoded word, [15:6] = run length and [5:0] = colour.
REQ-010 Port out_ready, input, 1: the consumer takes the word when out_valid && out_ready.
REQ-011 Port word_count, output, 16: the number of words handed off since reset; wraps at 16'hFFFF to 0.

Function
REQ-012 The encoder SHALL implement states EMPTY (no run held), RUN (run_len 1..MAX_RUN and run_colour held), FLUSH (a complete run is held and must be emitted) and MARK (end-of-row marker pending; macro only).
REQ-013 The output register SHALL be free when !out_valid || out_ready.
REQ-014 pix_ready SHALL equal (state is EMPTY or RUN) && output register free.
REQ-015 On an accepted pixel in EMPTY: run_len=1, run_colour=pix_colour, next state RUN.
REQ-016 In RUN, when the colour matches and run_len<MAX_RUN: run_len increments and no word is emitted.
REQ-017 In RUN, on a colour mismatch or when run_len==MAX_RUN: emit {run_len,run_colour} in the same cycle, then start a new run with run_len=1 and the new colour.
REQ-018 If the accepted pixel has pix_last and its run word can be emitted that cycle (EMPTY or matched in RUN): emit the run including that pixel.
  - Next state is EMPTY, or MARK when the macro is defined.
REQ-019 If pix_last arrives on a mismatch or MAX_RUN split: emit the old run, hold the new 1-pixel run, and go to FLUSH.
REQ-020 In FLUSH, when the output register is free: emit the held run.
  - Next state is EMPTY, or MARK when the macro is defined.
REQ-021 Runs SHALL never span rows.
REQ-022 A run SHALL be emitted only when split or ended by pix_last; no timeout flush.
REQ-023 Written words SHALL become visible (out_valid=1) on the cycle after they are written into the output register (latency 1).
REQ-024 out_data SHALL be stable while out_valid && !out_ready.
REQ-025 On a handoff with no new write, out_valid SHALL go to 0 the next cycle.
REQ-026 A handoff and a new write in the same cycle SHALL keep out_valid=1 with the new data.
REQ-027 word_count SHALL increment by 1 on each out_valid && out_ready cycle.
REQ-028 Pixels offered while pix_ready=0 SHALL be ignored; the source holds them.

Reset
REQ-029 While rst=1 at a clock edge:
  - state=EMPTY, run_len=0, run_colour=0
  - out_valid=0, out_data=16'h0000, word_count=0
REQ-030 Reset mid-run or mid-FLUSH/MARK SHALL discard all pending data with no partial word emitted.
REQ-031 pix_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-032 Macro RLE_ENC_EOL_MARKER_EN: when defined, after the last run of each row the encoder SHALL enter MARK.
  - In MARK, when the output register is free, emit 16'h0000 (length 0), then return to EMPTY.
  - pix_ready=0 while in MARK.
REQ-033 Without RLE_ENC_EOL_MARKER_EN: MARK is absent and a length-0 word is never emitted.

Verification
REQ-034 With out_ready=1, input 5x colour 6'h30 then 3x 6'h0C with pix_last on the 8th pixel -> out_data 16'h0170 then 16'h00CC; word_count=2 (macro off).
REQ-035 With MAX_RUN=1023, 1030x colour 6'h3F with pix_last on the last pixel -> words 16'hFFFF then 16'h01FF.
REQ-036 Input 6'h01 x2, then 6'h02 x1 with pix_last -> 16'h0081, then FLUSH -> 16'h0042; pix_ready=0 for exactly one cycle.
REQ-037 Hold out_ready=0 for 10 cycles with a word pending -> out_data held constant, pix_ready=0; release -> a single handoff and word_count +1.
REQ-038 Macro on, 4x colour 6'h15 with pix_last -> 16'h0115 then 16'h0000.
REQ-039 Assert rst during a run of 7 pixels -> next cycle out_valid=0, word_count=0, and a new run starts at length 1.
